// File: rtl/key_pkg.sv
// Shared constants and helpers for the multi-key event engine.
// Holds the short simulation cycle counts and the ms-to-cycles conversion.
package key_pkg;

  localparam int SIM_DB_CYC   = 500;
  localparam int SIM_LONG_CYC = 2000;
  localparam int SIM_REP_CYC  = 1000;

  // Divide before multiplying so large clocks and long hold times stay in int range.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce, then press/release/long/repeat events.
// deb is the debounced level; key_level is deb delayed one cycle so the pulses align with it.
module key_channel
  import key_pkg::*;
#(
  parameter int DB_CYC    = SIM_DB_CYC,
  parameter int LONG_CYC  = SIM_LONG_CYC,
  parameter int REP_CYC   = SIM_REP_CYC,
  parameter int REPEAT_EN = 1,
  parameter int CW        = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] LONG_VAL  = CW'(LONG_CYC);
  localparam logic [CW-1:0] REP_LAST  = CW'(LONG_CYC + REP_CYC - 1);

  logic          sync1, sync2, deb;
  logic [CW-1:0] db_cnt, hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      deb         <= 1'b0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;

      if (~sync2 != deb) begin
        if (db_cnt == DB_LAST) begin
          deb    <= ~deb;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end

      key_level   <= deb;
      key_press   <= deb & ~key_level;
      key_release <= ~deb & key_level;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;

      // Requiring deb as well keeps long/repeat out of the release cycle.
      if (deb && key_level) begin
        if (hold_cnt == LONG_LAST) begin
          hold_cnt <= LONG_VAL;
          key_long <= 1'b1;
        end else if (hold_cnt == REP_LAST) begin
          hold_cnt   <= LONG_VAL;
          key_repeat <= (REPEAT_EN != 0);
        end else if (hold_cnt < LONG_VAL || REPEAT_EN != 0) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/multi_key_event_engine.sv
// Multi-key debounce and event engine: derives cycle counts and replicates
// one key_channel per key.
module multi_key_event_engine
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 3,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int REPEAT_EN   = 1,
  parameter int SIMULATION  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int DB_CYC   = (SIMULATION != 0) ? SIM_DB_CYC   : ms_to_cyc(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = (SIMULATION != 0) ? SIM_LONG_CYC : ms_to_cyc(CLK_FREQ_HZ, LONG_MS);
  localparam int REP_CYC  = (SIMULATION != 0) ? SIM_REP_CYC  : ms_to_cyc(CLK_FREQ_HZ, REPEAT_MS);
  localparam int CW       = $clog2(max3(DB_CYC, LONG_CYC, REP_CYC)) + 1;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DB_CYC   (DB_CYC),
      .LONG_CYC (LONG_CYC),
      .REP_CYC  (REP_CYC),
      .REPEAT_EN(REPEAT_EN),
      .CW       (CW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g]),
      .key_repeat (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_multi_key_event_engine.sv
// Directed bench for multi_key_event_engine in SIMULATION mode (DB=500, LONG=2000, REP=1000).
// Cycle index 0 is the first clock edge that samples the new key_n value.
module tb_multi_key_event_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_n;
  logic [2:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [2:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_key_event_engine #(.NUM_KEYS(3), .SIMULATION(1), .REPEAT_EN(1)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat));

  multi_key_event_engine #(.NUM_KEYS(3), .SIMULATION(1), .REPEAT_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .key_n(key_n), .key_level(nr_level), .key_press(nr_press),
    .key_release(nr_release), .key_long(nr_long), .key_repeat(nr_repeat));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) $display("FAIL %s: got %0d, expected %0d", name, got, want);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_n = 3'b111;
    repeat (3) step();
    chk("reset_outputs", int'({key_level, key_press, key_release, key_long, key_repeat}), 0);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_level", int'(key_level), 0);
    chk("idle_pulses", int'({key_press, key_release, key_long, key_repeat}), 0);
  endtask

  task automatic test_short_press();
    int np = 0, nr = 0, nl = 0, ip = -1, ir = -1;
    key_n[0] = 1'b0;
    for (int i = 0; i < 1050; i++) begin
      step();
      if (key_press[0]) begin np++; ip = i; end
      if (key_long[0]) nl++;
    end
    key_n[0] = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (key_release[0]) begin nr++; ir = i; end
      if (key_long[0]) nl++;
    end
    chk("short_press_count", np, 1);
    chk("short_press_latency", ip, 502);
    chk("short_release_count", nr, 1);
    chk("short_release_latency", ir, 502);
    chk("short_long_count", nl, 0);
    chk("short_level_end", int'(key_level[0]), 0);
  endtask

  task automatic test_glitch();
    int ev = 0, lv = 0;
    key_n[1] = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (i == 300) key_n[1] = 1'b1;
      step();
      if (key_press[1] | key_release[1] | key_long[1] | key_repeat[1]) ev++;
      if (key_level[1]) lv++;
    end
    chk("glitch_events", ev, 0);
    chk("glitch_level", lv, 0);
  endtask

  task automatic test_long_repeat();
    int np = 0, nl = 0, nrp = 0, nrel = 0, clash = 0, il = -1, ir1 = -1, ir2 = -1;
    int xl = 0, xrp = 0, ixl = -1;
    key_n[2] = 1'b0;
    for (int i = 0; i < 5600; i++) begin
      if (i == 5000) key_n[2] = 1'b1;
      step();
      if (key_press[2]) np++;
      if (key_long[2]) begin nl++; il = i; end
      if (key_repeat[2]) begin
        nrp++;
        if (ir1 < 0) ir1 = i; else ir2 = i;
      end
      if (key_release[2]) nrel++;
      if (key_release[2] & (key_long[2] | key_repeat[2])) clash++;
      if (nr_long[2]) begin xl++; ixl = i; end
      if (nr_repeat[2]) xrp++;
    end
    chk("hold_press_count", np, 1);
    chk("hold_long_count", nl, 1);
    chk("hold_long_time", il, 2502);
    chk("hold_repeat_count", nrp, 2);
    chk("hold_repeat1_time", ir1, 3502);
    chk("hold_repeat2_time", ir2, 4502);
    chk("hold_release_count", nrel, 1);
    chk("hold_release_clash", clash, 0);
    chk("norep_long_count", xl, 1);
    chk("norep_long_time", ixl, 2502);
    chk("norep_repeat_count", xrp, 0);
  endtask

  task automatic test_simultaneous();
    int both = 0, i0 = -1, i1 = -1;
    key_n[1:0] = 2'b00;
    for (int i = 0; i < 600; i++) begin
      step();
      if (key_press[0]) i0 = i;
      if (key_press[1]) i1 = i;
      if (key_press[0] & key_press[1]) both++;
    end
    key_n[1:0] = 2'b11;
    repeat (600) step();
    chk("simul_same_cycle", both, 1);
    chk("simul_press0_time", i0, 502);
    chk("simul_press1_time", i1, 502);
    chk("simul_released", int'(key_level), 0);
  endtask

  task automatic test_reset_mid_press();
    int ip = -1, nrel = 0, np = 0;
    key_n[0] = 1'b0;
    for (int i = 0; i < 503 + 1500; i++) begin
      step();
      if (key_release[0]) nrel++;
    end
    chk("midrst_level_before", int'(key_level[0]), 1);
    rst = 1'b1;
    step();
    chk("midrst_outputs_clear", int'({key_level, key_press, key_release, key_long, key_repeat}), 0);
    rst = 1'b0;
    for (int i = 0; i < 700; i++) begin
      step();
      if (key_press[0]) begin np++; ip = i; end
      if (key_release[0]) nrel++;
    end
    chk("midrst_press_count", np, 1);
    chk("midrst_press_time", ip, 502);
    chk("midrst_no_release", nrel, 0);
    key_n[0] = 1'b1;
    repeat (600) step();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_glitch();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_key_event_engine.md
MULTI_KEY_EVENT_ENGINE -- requirements
Module: multi_key_event_engine

Interface
REQ-001 Parameter NUM_KEYS, default 3: number of independent key channels (1..16).
REQ-002 Parameter CLK_FREQ_HZ, default 50_000_000: system clock frequency.
REQ-003 Parameter DEBOUNCE_MS, default 20: stable time required before a level change is accepted.
REQ-004 Parameter LONG_MS, default 1000: continuous hold time before a long-press event.
REQ-005 Parameter REPEAT_MS, default 200: auto-repeat interval after a long press.
REQ-006 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 suppresses all repeat events.
REQ-007 Parameter SIMULATION, default 0: 1 replaces the time-derived counts with DB_CYC=500, LONG_CYC=2000, REP_CYC=1000.
REQ-008 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-009 Port rst, input, 1: reset, synchronous and active-high.
REQ-010 Port key_n, input, NUM_KEYS: raw asynchronous keys, active-low (0 = pressed).
REQ-011 Port key_level, output, NUM_KEYS: debounced state, 1 = pressed.
REQ-012 Port key_press, output, NUM_KEYS: one-cycle pulse on an accepted press.
REQ-013 Port key_release, output, NUM_KEYS: one-cycle pulse on an accepted release.
REQ-014 Port key_long, output, NUM_KEYS: one-cycle pulse when a hold reaches LONG_CYC.
REQ-015 Port key_repeat, output, NUM_KEYS: one-cycle pulse every REP_CYC after key_long while the key is held.

Function
REQ-016 Cycle counts: DB_CYC=CLK_FREQ_HZ/1000*DEBOUNCE_MS, LONG_CYC and REP_CYC likewise, unless SIMULATION=1; counter width is $clog2 of the largest count plus 1.
REQ-017 Each key_n bit passes through a 2-flop synchroniser, reset value 1.
REQ-018 Per channel, while the synchronised input differs from key_level, a debounce counter increments each cycle; any cycle where they agree clears it to 0.
REQ-019 When the debounce counter reaches DB_CYC-1 with input still differing, key_level toggles next edge and the counter clears.
REQ-020 key_press (key_release) is asserted in the same cycle key_level first reads 1 (0); steady low key_n yields key_press exactly DB_CYC+2 cycles after the first edge sampling 0.
REQ-021 Glitches shorter than DB_CYC cycles at the synchroniser output produce no level change and no events.
REQ-022 Hold counter clears on key_press and increments each cycle while key_level=1; key_long pulses when it reaches LONG_CYC, once per press.
REQ-023 After key_long, key_repeat pulses every REP_CYC cycles while held (first at LONG_CYC+REP_CYC) when REPEAT_EN=1; never when REPEAT_EN=0.
REQ-024 Hold counter saturates/wraps only within the repeat interval: after LONG_CYC it reloads to LONG_CYC on each repeat, so no overflow for unbounded hold.
REQ-025 Release at any point clears the hold counter and cancels pending long/repeat; key_release and key_long/key_repeat are never asserted in the same cycle.
REQ-026 Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.

Reset
REQ-027 While rst=1 at a clock edge: synchronisers to 1, all counters to 0, key_level=0, all pulse outputs 0.
REQ-028 Reset mid-press: after rst deasserts with key_n still low, a fresh key_press occurs DB_CYC+2 cycles later; no key_release is generated by reset.

Structure
REQ-029 Shared package key_pkg holds the SIMULATION cycle constants (500/2000/1000) and the ms-to-cycles constant function.
REQ-030 One sub-module key_channel (synchroniser, debounce, hold/repeat logic for one key), instantiated NUM_KEYS times via generate; top level is wiring only.

Verification (NUM_KEYS=3, SIMULATION=1, 50 MHz)
REQ-031 key_n[0] low for 21 us (1050 cyc) -> key_press[0] one pulse 502 cycles after first low sample; key_release[0] 502 cycles after return high; no long.
REQ-032 key_n[1] low for 300 cycles, then high -> no events, key_level[1] stays 0.
REQ-033 key_n[2] held low 5000 cycles -> key_long at hold 2000, key_repeat at 3000 and 4000; exactly one press, one long, two repeats.
REQ-034 Same as REQ-033 with REPEAT_EN=0 -> key_long only, zero repeats.
REQ-035 key_n[0] and key_n[1] fall on the same edge -> key_press[0] and key_press[1] in the same cycle.
REQ-036 rst pulsed 1 cycle at hold count 1500 with key_n[0] held low -> all outputs 0 next cycle, new key_press[0] 502 cycles after rst deasserts, no key_release.
